// File: rtl/chacha_qr_bus_pkg.sv
// Shared types and field positions for the byte-wide ChaCha quarter-round register bus.
// Word a sits in the least significant 32 bits of a flattened job, so byte k lives at bits 8k+7:8k.
package chacha_qr_bus_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned NUM_WORDS = 4;
    localparam int unsigned NUM_BYTES = 16;
    localparam int unsigned JOB_W     = WORD_W * NUM_WORDS;
    localparam int unsigned ADDR_W    = 4;

    localparam int unsigned WORD_SEL_MSB = 3;
    localparam int unsigned WORD_SEL_LSB = 2;
    localparam int unsigned BYTE_SEL_MSB = 1;
    localparam int unsigned BYTE_SEL_LSB = 0;

    localparam logic [1:0] WORD_A = 2'd0;
    localparam logic [1:0] WORD_B = 2'd1;
    localparam logic [1:0] WORD_C = 2'd2;
    localparam logic [1:0] WORD_D = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_QR    = 3'd2,
        ST_WAIT  = 3'd3,
        ST_READ  = 3'd4,
        ST_DONE  = 3'd5
    } qr_state_e;

    typedef struct packed {
        logic [WORD_W-1:0] d;
        logic [WORD_W-1:0] c;
        logic [WORD_W-1:0] b;
        logic [WORD_W-1:0] a;
    } qr_job_t;

    // Byte selected by a bus address: word from [3:2], byte lane from [1:0].
    function automatic logic [BYTE_W-1:0] job_byte(input qr_job_t job,
                                                   input logic [ADDR_W-1:0] addr);
        logic [WORD_W-1:0] word;
        case (addr[WORD_SEL_MSB:WORD_SEL_LSB])
            WORD_A:  word = job.a;
            WORD_B:  word = job.b;
            WORD_C:  word = job.c;
            default: word = job.d;
        endcase
        return word[{addr[BYTE_SEL_MSB:BYTE_SEL_LSB], 3'b000} +: BYTE_W];
    endfunction

endpackage

// File: rtl/chacha_qr_host.sv
// Host initiator: streams a 128-bit job into the quarter-round peripheral byte by byte,
// pulses the round strobe ROUNDS times, reads the 16 result bytes back and presents them.
module chacha_qr_host
    import chacha_qr_bus_pkg::*;
#(
    parameter int unsigned ROUNDS       = 1,
    parameter int unsigned QR_WAIT      = 1,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WORD_W-1:0]   in_a,
    input  logic [WORD_W-1:0]   in_b,
    input  logic [WORD_W-1:0]   in_c,
    input  logic [WORD_W-1:0]   in_d,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WORD_W-1:0]   out_a,
    output logic [WORD_W-1:0]   out_b,
    output logic [WORD_W-1:0]   out_c,
    output logic [WORD_W-1:0]   out_d,
    output logic [BYTE_W-1:0]   bus_wdata,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic                bus_wr_en,
    output logic                bus_qr_en,
    input  logic [BYTE_W-1:0]   bus_rdata,
    output logic                busy
);

    localparam logic [3:0] ROUNDS_CFG = 4'(ROUNDS);
    localparam logic [2:0] WAIT_LAST  = 3'(QR_WAIT - 1);
    localparam logic [2:0] RD_LAT     = 3'(READ_LATENCY);
    localparam logic [3:0] LAST_IDX   = 4'(NUM_BYTES - 1);

    qr_state_e         state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic [3:0]        cap_q, cap_d;
    logic [3:0]        round_q, round_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              addr_done_q, addr_done_d;
    qr_job_t           shadow_q, shadow_d;
    qr_job_t           result_q, result_d;

    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [BYTE_W-1:0] bus_wdata_q, bus_wdata_d;
    logic              bus_wr_en_q, bus_wr_en_d;
    logic              bus_qr_en_q, bus_qr_en_d;

    logic              accept;
    logic [JOB_W-1:0]  result_flat;

    assign accept = (state_q == ST_IDLE) && in_valid && in_ready_q;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath next values.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cap_d       = cap_q;
        round_d     = round_q;
        cnt_d       = cnt_q;
        addr_done_d = addr_done_q;
        shadow_d    = shadow_q;
        result_d    = result_q;
        result_flat = result_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shadow_d.a = in_a;
                    shadow_d.b = in_b;
                    shadow_d.c = in_c;
                    shadow_d.d = in_d;
                    idx_d      = 4'd0;
                    state_d    = ST_WRITE;
                end
            end
            ST_WRITE: begin
                idx_d = 4'(idx_q + 4'd1);
                if (idx_q == LAST_IDX) begin
                    idx_d       = 4'd0;
                    cap_d       = 4'd0;
                    round_d     = 4'd0;
                    cnt_d       = 3'd0;
                    addr_done_d = 1'b0;
                    state_d     = (ROUNDS_CFG == 4'd0) ? ST_READ : ST_QR;
                end
            end
            ST_QR: begin
                round_d = 4'(round_q + 4'd1);
                cnt_d   = 3'd0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = 3'(cnt_q + 3'd1);
                if (cnt_q == WAIT_LAST) begin
                    cnt_d   = 3'd0;
                    state_d = (round_q < ROUNDS_CFG) ? ST_QR : ST_READ;
                end
            end
            ST_READ: begin
                if (!addr_done_q) begin
                    idx_d = 4'(idx_q + 4'd1);
                    if (idx_q == LAST_IDX) begin
                        addr_done_d = 1'b1;
                    end
                end
                // First RD_LAT cycles only prime the read pipe; then one byte lands per cycle.
                if (cnt_q < RD_LAT) begin
                    cnt_d = 3'(cnt_q + 3'd1);
                end else begin
                    result_flat[{cap_q, 3'b000} +: BYTE_W] = bus_rdata;
                    result_d = qr_job_t'(result_flat);
                    cap_d    = 4'(cap_q + 4'd1);
                    if (cap_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output next values, derived from the upcoming state so the registered pins line up with it.
    always_comb begin
        in_ready_d  = 1'b0;
        busy_d      = 1'b0;
        out_valid_d = 1'b0;
        bus_addr_d  = '0;
        bus_wdata_d = '0;
        bus_wr_en_d = 1'b0;
        bus_qr_en_d = 1'b0;

        case (state_d)
            ST_IDLE: begin
                in_ready_d = 1'b1;
            end
            ST_WRITE: begin
                busy_d      = 1'b1;
                bus_wr_en_d = 1'b1;
                bus_addr_d  = idx_d;
                bus_wdata_d = job_byte(shadow_d, idx_d);
            end
            ST_QR: begin
                busy_d      = 1'b1;
                bus_qr_en_d = 1'b1;
            end
            ST_WAIT: begin
                busy_d = 1'b1;
            end
            ST_READ: begin
                busy_d     = 1'b1;
                bus_addr_d = addr_done_d ? '0 : idx_d;
            end
            ST_DONE: begin
                busy_d      = 1'b1;
                out_valid_d = 1'b1;
            end
            default: begin
                busy_d = 1'b1;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q       <= '0;
            cap_q       <= '0;
            round_q     <= '0;
            cnt_q       <= '0;
            addr_done_q <= 1'b0;
            shadow_q    <= '0;
            result_q    <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_wr_en_q <= 1'b0;
            bus_qr_en_q <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            cap_q       <= cap_d;
            round_q     <= round_d;
            cnt_q       <= cnt_d;
            addr_done_q <= addr_done_d;
            shadow_q    <= shadow_d;
            result_q    <= result_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_wr_en_q <= bus_wr_en_d;
            bus_qr_en_q <= bus_qr_en_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_a     = result_q.a;
    assign out_b     = result_q.b;
    assign out_c     = result_q.c;
    assign out_d     = result_q.d;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_wr_en = bus_wr_en_q;
    assign bus_qr_en = bus_qr_en_q;

endmodule

// File: doc/chacha_qr_host.md
# chacha_qr_host

Host-side initiator for the byte-wide ChaCha quarter-round register bus. It accepts a 128-bit job (words a, b, c, d) over a valid/ready stream and writes the words into the quarter-round peripheral one byte per cycle. It then pulses the quarter-round enable the configured number of times, reads all 16 result bytes back, and presents the four result words on a valid/ready output stream. It sits between a stream-oriented core (keystream generator, test harness) and the peripheral's `ui_in`/`uo_out`/`uio_in` pins.

## Interface
- `ROUNDS`, 1: number of quarter-round pulses per job. Legal range 0..15; 0 means write/readback loopback with no pulse.
- `QR_WAIT`, 1: idle cycles after each pulse before the next pulse or the readback. Legal range 1..7.
- `READ_LATENCY`, 1: cycles from an address being driven to its byte being valid on `bus_rdata`. Legal range 1..3.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset; synchronous and active-low.
- `in_valid`  in  1  job available.
- `in_ready`  out  1  high only in IDLE.
- `in_a`, `in_b`, `in_c`, `in_d`  in  32 each  job words.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts.
- `out_a`, `out_b`, `out_c`, `out_d`  out  32 each  result words.
- `bus_wdata`  out  8  byte driven to the peripheral data input.
- `bus_addr`  out  4  bits [3:2] select the word (0=a, 1=b, 2=c, 3=d); bits [1:0] select the byte (0 = bits 7:0 … 3 = bits 31:24).
- `bus_wr_en`  out  1  peripheral write strobe.
- `bus_qr_en`  out  1  peripheral quarter-round strobe.
- `bus_rdata`  in  8  registered read byte from the peripheral.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- **Reset values:** all outputs are 0. State is IDLE. `in_ready` becomes 1 on the first cycle after reset is released.
- **FSM states:** IDLE → WRITE → (QR → WAIT)×ROUNDS → READ → DONE → IDLE.
- **IDLE:** `in_ready`=1 and the bus is quiescent (`bus_addr`=0, both strobes 0). On `in_valid && in_ready`, latch the four input words into a 128-bit shadow, clear the byte index, and go to WRITE.
- **WRITE:** runs 16 cycles, index k = 0..15. Drives `bus_addr`=k, `bus_wr_en`=1, `bus_qr_en`=0, and `bus_wdata` = byte k of the shadow. Byte k is word k[3:2], bits 8·k[1:0]+7 : 8·k[1:0].
- **QR:** one cycle with `bus_qr_en`=1, `bus_wr_en`=0, `bus_addr`=0. Increments the round counter.
- **WAIT:** QR_WAIT cycles with both strobes 0. Exits to QR if the round counter < ROUNDS, otherwise to READ. When ROUNDS=0, WRITE goes directly to READ.
- **READ:** runs 16+READ_LATENCY cycles. In the first 16 cycles it drives `bus_addr`=k for k = 0..15; after that `bus_addr` holds at 0. Capture index j = k delayed by READ_LATENCY. `bus_rdata` is stored into byte j of the result register on each cycle where j is valid. Both strobes stay 0 throughout.
- **DONE:** `out_valid`=1 and `out_*` are held stable. On `out_ready` go to IDLE; `out_valid` falls on the next cycle.
- **Ignored inputs:** `in_valid` outside IDLE; `out_ready` outside DONE.
- **Exclusivity:** `bus_wr_en` and `bus_qr_en` are never high in the same cycle.
- **Reset mid-operation:** from any state, return to IDLE with all outputs zeroed and the partial result discarded. The peripheral contents are left undefined.
- **Counter widths:** byte index 4 bits, wraps at 16 (no 17th access). Round counter 4 bits. Wait/latency counter 3 bits.

## Timing
- **Accept edge = edge 0.** WRITE occupies cycles 1..16, QR/WAIT follow, and READ follows those.
- **Latency:** `out_valid` rises 17 + ROUNDS·(1+QR_WAIT) + 16 + READ_LATENCY cycles after the accept edge. With defaults this is 36.
- **Throughput:** the next `in_ready` comes one cycle after the output handshake, so back-to-back jobs have a 1-cycle IDLE gap.
- **Output timing:** all bus outputs are registered, so there is no combinational path from `bus_rdata` or `in_*` to any output.

## Structure
- **Package `chacha_qr_bus_pkg`:** holds the FSM state enum and the address field positions (word select [3:2], byte select [1:0]). It also holds the word-index constants A=0, B=1, C=2, D=3 and the byte count 16.
- **Sub-modules:** none; the block is a single module.
- **Testbench:** the bench instantiates a behavioural model of the peripheral with a single-cycle quarter round and a registered read (READ_LATENCY=1).

## Test plan
1. **RFC 8439 §2.1.1 vector:** job a=0x11111111, b=0x01020304, c=0x9b8d6f43, d=0x01234567 with ROUNDS=1 → out a=0xea2a92f4, b=0xcb1cf8ce, c=0x4581472e, d=0x5881c4bb; `out_valid` on cycle 36.
2. **Loopback:** ROUNDS=0, job a=0xDEADBEEF, b=0x01234567, c=0x89ABCDEF, d=0xCAFEF00D → output equals input. Write address sequence is 0..15 with `wr_en` high for exactly 16 cycles.
3. **Backpressure:** `out_ready` held low for 20 cycles → `out_*` stable and `out_valid` held. A simultaneous `in_valid` is not accepted (`in_ready`=0) until 1 cycle after the handshake.
4. **Reset mid-operation:** assert `rst_n`=0 during WRITE index 7 and again during READ → next cycle all outputs are 0 and the state is IDLE. A fresh job then completes correctly.
5. **Latency sweep:** READ_LATENCY=3 and QR_WAIT=2 with the model's read delayed to match → results correct and `out_valid` on cycle 17+3+16+3 = 39.
6. **Repeated rounds:** ROUNDS=2 on the vector from test 1 → output equals a double quarter-round from the software model. Exactly two `qr_en` pulses, separated by QR_WAIT cycles.
